// File: rtl/debug_probe_display.sv
// Debug front-end: probe channel select and freeze, scanned hex display, LED mirror,
// and run/halt/single-step clock-enable control for the core.
module debug_probe_display #(
    parameter int NUM_CH     = 16,
    parameter int DATA_W     = 32,
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 1024,
    parameter int LED_W      = 26,
    parameter int RESET_RUN  = 1
) (
    input  logic                         SYS_clk,
    input  logic                         SYS_reset,
    input  logic [NUM_CH*DATA_W-1:0]     probe_data,
    input  logic [$clog2(NUM_CH)-1:0]    select,
    input  logic                         freeze,
    input  logic                         mode_run,
    input  logic                         step_req,
    output logic                         cpu_en,
    output logic [15:0]                  cycle_count,
    output logic [LED_W-1:0]             led_out,
    output logic [6:0]                   seg_out,
    output logic [NUM_DIGITS-1:0]        digit_en
);
    // state | meaning
    // RUN   | core clock enabled continuously
    // HALT  | core stopped, waiting for mode_run or a step edge
    // STEP  | single enabled cycle, then back to HALT or RUN
    typedef enum logic [1:0] {RUN, HALT, STEP} run_state_t;

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    run_state_t         state;
    logic               step_q;
    logic               freeze_q;
    logic [DATA_W-1:0]  snap;
    logic [DATA_W-1:0]  disp_val;
    logic [PRE_W-1:0]   prescaler;
    logic [IDX_W-1:0]   idx;

    logic [DATA_W-1:0]  live;
    logic [DATA_W-1:0]  snap_nxt;
    logic [DATA_W-1:0]  disp_nxt;
    logic [PRE_W-1:0]   pre_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic [3:0]         nib;
    logic [6:0]         seg_nxt;
    logic               step_edge;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        live = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(select) == k) live = probe_data[k*DATA_W +: DATA_W];
        end
    end

    // Snapshot bypass so the capture cycle already displays the captured value.
    assign snap_nxt  = (freeze & ~freeze_q) ? live : snap;
    assign disp_nxt  = freeze ? snap_nxt : live;
    assign step_edge = step_req & ~step_q;

    // Display outputs are registered from the next index/value so they always match each other.
    always_comb begin
        pre_nxt = prescaler + 1'b1;
        idx_nxt = idx;
        if (prescaler == PRE_LAST) begin
            pre_nxt = '0;
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
        nib     = 4'(disp_nxt >> (4 * idx_nxt));
        seg_nxt = (int'(idx_nxt) >= DATA_W / 4) ? 7'h7F : hex7(nib);
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            freeze_q  <= 1'b0;
            snap      <= '0;
            disp_val  <= '0;
            prescaler <= '0;
            idx       <= '0;
            seg_out   <= 7'h40;
            digit_en  <= ~NUM_DIGITS'(1);
        end else begin
            freeze_q  <= freeze;
            snap      <= snap_nxt;
            disp_val  <= disp_nxt;
            prescaler <= pre_nxt;
            idx       <= idx_nxt;
            seg_out   <= seg_nxt;
            digit_en  <= ~(NUM_DIGITS'(1) << idx_nxt);
        end
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            state       <= (RESET_RUN != 0) ? RUN : HALT;
            cpu_en      <= (RESET_RUN != 0);
            step_q      <= 1'b0;
            cycle_count <= '0;
        end else begin
            step_q      <= step_req;
            cycle_count <= cycle_count + {15'd0, cpu_en};
            case (state)
                RUN: begin
                    if (!mode_run) begin
                        state  <= HALT;
                        cpu_en <= 1'b0;
                    end else begin
                        cpu_en <= 1'b1;
                    end
                end
                HALT: begin
                    if (mode_run) begin
                        state  <= RUN;
                        cpu_en <= 1'b1;
                    end else if (step_edge) begin
                        state  <= STEP;
                        cpu_en <= 1'b1;
                    end else begin
                        cpu_en <= 1'b0;
                    end
                end
                STEP: begin
                    state  <= mode_run ? RUN : HALT;
                    cpu_en <= mode_run;
                end
                default: begin
                    state  <= HALT;
                    cpu_en <= 1'b0;
                end
            endcase
        end
    end

    assign led_out = disp_val[LED_W-1:0];

endmodule

// File: tb/tb_debug_probe_display.sv
// Self-checking bench for debug_probe_display: directed steps plus randomized probe,
// freeze and step traffic compared with a rule-level reference model.
module tb_debug_probe_display;
    localparam int NUM_CH     = 12;
    localparam int DATA_W     = 32;
    localparam int NUM_DIGITS = 8;
    localparam int SCAN_DIV   = 4;
    localparam int LED_W      = 26;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_CH*DATA_W-1:0]  probe_data;
    logic [3:0]                sel;
    logic                      freeze, mode_run, step_req;
    logic                      cpu_en;
    logic [15:0]               cycle_count;
    logic [LED_W-1:0]          led_out;
    logic [6:0]                seg_out;
    logic [NUM_DIGITS-1:0]     digit_en;

    logic [31:0] ch [NUM_CH];

    int n_err = 0;
    int n_chk = 0;

    // reference model state
    logic        m_en, m_step_q, m_freeze_q;
    logic [15:0] m_cnt;
    logic [31:0] m_snap, m_disp;
    int          m_n;

    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    debug_probe_display #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS),
        .SCAN_DIV(SCAN_DIV), .LED_W(LED_W), .RESET_RUN(1)
    ) dut (
        .SYS_clk(clk), .SYS_reset(rst_n), .probe_data(probe_data), .select(sel),
        .freeze(freeze), .mode_run(mode_run), .step_req(step_req), .cpu_en(cpu_en),
        .cycle_count(cycle_count), .led_out(led_out), .seg_out(seg_out), .digit_en(digit_en)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) probe_data[k*DATA_W +: DATA_W] = ch[k];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 1'b1; m_cnt = 16'd0; m_snap = 32'd0; m_disp = 32'd0;
        m_step_q = 1'b0; m_freeze_q = 1'b0; m_n = 0;
    endtask

    // Advance the model by one clock with the inputs currently driven, then pass the edge.
    task automatic tick();
        logic [31:0] live;
        live = (int'(sel) < NUM_CH) ? ch[sel] : 32'd0;
        if (freeze && !m_freeze_q) m_snap = live;
        m_disp = freeze ? m_snap : live;
        m_cnt  = m_cnt + {15'd0, m_en};
        m_en   = mode_run | (!m_en & step_req & !m_step_q);
        m_step_q   = step_req;
        m_freeze_q = freeze;
        m_n++;
        @(posedge clk); #1;
    endtask

    task automatic check_all(input string tag);
        int idx;
        logic [7:0] den;
        idx = (m_n / SCAN_DIV) % NUM_DIGITS;
        den = ~(8'd1 << idx);
        chk({tag, ".cpu_en"}, 64'(cpu_en), 64'(m_en));
        chk({tag, ".count"}, 64'(cycle_count), 64'(m_cnt));
        chk({tag, ".led"}, 64'(led_out), 64'(m_disp[LED_W-1:0]));
        chk({tag, ".digit_en"}, 64'(digit_en), 64'(den));
        chk({tag, ".seg"}, 64'(seg_out), 64'(HEX[(m_disp >> (4*idx)) & 32'hF]));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < NUM_CH; k++) ch[k] = 32'd0;
        sel = 4'd0; freeze = 1'b0; mode_run = 1'b1; step_req = 1'b0;
        rst_n = 1'b1;
        #2;
        apply_reset();

        // free run for 100 cycles
        for (int i = 0; i < 100; i++) tick();
        chk("run100.count", 64'(cycle_count), 64'd100);
        check_all("run100");

        // halt, then a held step request gives exactly one pulse
        mode_run = 1'b0;
        tick(); check_all("halt");
        step_req = 1'b1;
        tick(); chk("step1.pulse", 64'(cpu_en), 64'd1); check_all("step1");
        for (int i = 0; i < 49; i++) begin
            tick(); chk("step1.held", 64'(cpu_en), 64'd0);
        end
        check_all("step1.end");
        chk("step1.count", 64'(cycle_count), 64'd102);
        step_req = 1'b0; tick();
        step_req = 1'b1; tick(); chk("step2.pulse", 64'(cpu_en), 64'd1);
        tick(); check_all("step2.end");
        chk("step2.count", 64'(cycle_count), 64'd103);

        // mode_run rising together with a step edge goes to RUN
        step_req = 1'b0; tick();
        step_req = 1'b1; mode_run = 1'b1;
        tick(); check_all("prio.a");
        tick(); check_all("prio.b");
        tick(); chk("prio.run", 64'(cpu_en), 64'd1);
        mode_run = 1'b0; step_req = 1'b0;
        tick(); check_all("prio.halt");

        // live channel display and digit decode
        ch[3] = 32'hDEADBEEF; sel = 4'd3;
        tick(); chk("live.led", 64'(led_out), 64'h2ADBEEF);
        for (int i = 0; i < 2 * SCAN_DIV * NUM_DIGITS; i++) begin
            tick(); check_all("scan");
            if (digit_en == 8'hFE) chk("digit0.F", 64'(seg_out), 64'h0E);
            if (digit_en == 8'h7F) chk("digit7.D", 64'(seg_out), 64'h21);
        end

        // freeze holds the snapshot against probe and select changes
        freeze = 1'b1; tick(); check_all("frz.edge");
        ch[3] = 32'd0; ch[5] = $urandom; sel = 4'd5;
        for (int i = 0; i < 6; i++) begin
            tick(); chk("frz.hold", 64'(led_out), 64'h2ADBEEF);
        end
        freeze = 1'b0;
        tick(); chk("frz.release", 64'(led_out), 64'(ch[5][LED_W-1:0]));

        // out-of-range select reads zero
        sel = 4'd12; ch[0] = 32'hFFFFFFFF;
        tick(); chk("sel_oor.led", 64'(led_out), 64'd0); check_all("sel_oor");

        // randomized probe, select, freeze and step traffic while halted
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NUM_CH; k++) ch[k] = $urandom;
            sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) freeze = ~freeze;
            step_req = ($urandom_range(0, 2) == 0);
            tick(); check_all("rand");
        end

        // reset in the middle of a scan slot
        tick(); tick(); tick();
        #2;
        apply_reset();
        chk("midreset.digit_en", 64'(digit_en), 64'hFE);
        freeze = 1'b0; step_req = 1'b0; mode_run = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick(); check_all("post_reset");
        end

        // cycle counter wrap, bounded
        for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) tick();
        chk("wrap.pre", 64'(cycle_count), 64'hFFFF);
        tick(); chk("wrap.zero", 64'(cycle_count), 64'h0);
        check_all("wrap");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
